axis_pkt_fifo: RTL and testbench

Packet-aware AXI-Stream FIFO placed directly downstream of the byte-shift stage. It decouples that stage's pass-through ready from the sink with real buffering. It absorbs null beats (tkeep all zero) that the shifter emits. An optional store-and-forward mode releases a packet only once its tlast beat is buffered. It also provides fill-level and packet-count status for flow control.

---
 rtl/axis_pkt_fifo.sv | 117 +++++++++++
 tb/tb_axis_pkt_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// Packet-aware AXI-Stream FIFO with null-beat absorption,
// optional store-and-forward release and fill/packet status.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64,
  parameter int STORE_FWD  = 0,
  parameter int DROP_NULL  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          i_AXI_slave_data,
  input  logic                           i_AXI_slave_valid_p,
  input  logic [DATA_WIDTH/8-1:0]        i_AXI_slave_tkeep,
  input  logic                           i_AXI_slave_tlast,
  output logic                           o_AXI_slave_ready,
  output logic [DATA_WIDTH-1:0]          o_AXI_master_data,
  output logic                           o_AXI_master_valid_p,
  output logic [DATA_WIDTH/8-1:0]        o_AXI_master_tkeep,
  output logic                           o_AXI_master_tlast,
  input  logic                           i_AXI_master_ready,
  output logic [$clog2(DEPTH+1)-1:0]     o_fill_level,
  output logic [$clog2(DEPTH+1)-1:0]     o_pkt_count,
  output logic                           o_oversize
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  last;
    logic [KW-1:0]         keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t          mem [DEPTH];
  beat_t          head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fill;
  logic [CW-1:0]  pkts;
  logic [CW-1:0]  fill_nxt;
  logic [CW-1:0]  pkts_nxt;
  logic           ready_q;
  logic           force_q;
  logic           ovs_q;
  logic           push;
  logic           is_null;
  logic           wr_en;
  logic           can_rel;
  logic           valid;
  logic           pop;
  logic           ovs_hit;

  assign head    = mem[rd_ptr];
  assign push    = i_AXI_slave_valid_p & ready_q;
  assign is_null = (DROP_NULL != 0) &&
                   (i_AXI_slave_tkeep == '0) &&
                   !i_AXI_slave_tlast;
  assign wr_en   = push & !is_null;

  // a packet waits for its tlast unless it can never fit
  assign can_rel = (STORE_FWD == 0) || (pkts != '0) || force_q;
  assign valid   = (fill != '0) && can_rel;
  assign pop     = valid & i_AXI_master_ready;

  assign ovs_hit = (STORE_FWD != 0) &&
                   (fill == CW'(DEPTH)) &&
                   (pkts == '0);

  assign fill_nxt = fill + CW'(wr_en) - CW'(pop);
  assign pkts_nxt = pkts
                  + CW'(wr_en & i_AXI_slave_tlast)
                  - CW'(pop & head.last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      pkts    <= '0;
      ready_q <= 1'b0;
      force_q <= 1'b0;
      ovs_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      fill    <= fill_nxt;
      pkts    <= pkts_nxt;
      ready_q <= (fill_nxt != CW'(DEPTH));
      if (ovs_hit) begin
        force_q <= 1'b1;
        ovs_q   <= 1'b1;
      end else if (pop && head.last) begin
        force_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{last: i_AXI_slave_tlast,
                       keep: i_AXI_slave_tkeep,
                       data: i_AXI_slave_data};
    end
  end

  assign o_AXI_slave_ready    = ready_q;
  assign o_AXI_master_valid_p = valid;
  assign o_AXI_master_data    = valid ? head.data : '0;
  assign o_AXI_master_tkeep   = valid ? head.keep : '0;
  assign o_AXI_master_tlast   = valid ? head.last : 1'b0;
  assign o_fill_level         = fill;
  assign o_pkt_count          = pkts;
  assign o_oversize           = ovs_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed scoreboard bench for axis_pkt_fifo in cut-through,
// store-and-forward and oversize configurations.
module tb_axis_pkt_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic [3:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  int          sel = 0;

  logic        a_rdy, a_mv, a_ml, a_ov;
  logic [31:0] a_md;
  logic [3:0]  a_mk;
  logic [2:0]  a_fl, a_pc;
  logic        b_rdy, b_mv, b_ml, b_ov;
  logic [31:0] b_md;
  logic [3:0]  b_mk;
  logic [3:0]  b_fl, b_pc;
  logic        c_rdy, c_mv, c_ml, c_ov;
  logic [31:0] c_md;
  logic [3:0]  c_mk;
  logic [2:0]  c_fl, c_pc;

  logic        s_ready, m_valid, m_last, ovs;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [3:0]  fill, pkt;

  logic [36:0] q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(4), .STORE_FWD(0), .DROP_NULL(1)) u_a (
    .clk(clk), .reset(reset),
    .i_AXI_slave_data(s_data), .i_AXI_slave_valid_p(s_valid),
    .i_AXI_slave_tkeep(s_keep), .i_AXI_slave_tlast(s_last),
    .o_AXI_slave_ready(a_rdy),
    .o_AXI_master_data(a_md), .o_AXI_master_valid_p(a_mv),
    .o_AXI_master_tkeep(a_mk), .o_AXI_master_tlast(a_ml),
    .i_AXI_master_ready(m_ready),
    .o_fill_level(a_fl), .o_pkt_count(a_pc), .o_oversize(a_ov)
  );

  axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(8), .STORE_FWD(1), .DROP_NULL(1)) u_b (
    .clk(clk), .reset(reset),
    .i_AXI_slave_data(s_data), .i_AXI_slave_valid_p(s_valid),
    .i_AXI_slave_tkeep(s_keep), .i_AXI_slave_tlast(s_last),
    .o_AXI_slave_ready(b_rdy),
    .o_AXI_master_data(b_md), .o_AXI_master_valid_p(b_mv),
    .o_AXI_master_tkeep(b_mk), .o_AXI_master_tlast(b_ml),
    .i_AXI_master_ready(m_ready),
    .o_fill_level(b_fl), .o_pkt_count(b_pc), .o_oversize(b_ov)
  );

  axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(4), .STORE_FWD(1), .DROP_NULL(1)) u_c (
    .clk(clk), .reset(reset),
    .i_AXI_slave_data(s_data), .i_AXI_slave_valid_p(s_valid),
    .i_AXI_slave_tkeep(s_keep), .i_AXI_slave_tlast(s_last),
    .o_AXI_slave_ready(c_rdy),
    .o_AXI_master_data(c_md), .o_AXI_master_valid_p(c_mv),
    .o_AXI_master_tkeep(c_mk), .o_AXI_master_tlast(c_ml),
    .i_AXI_master_ready(m_ready),
    .o_fill_level(c_fl), .o_pkt_count(c_pc), .o_oversize(c_ov)
  );

  always_comb begin
    s_ready = a_rdy; m_valid = a_mv; m_last = a_ml; ovs = a_ov;
    m_data = a_md; m_keep = a_mk;
    fill = {1'b0, a_fl}; pkt = {1'b0, a_pc};
    case (sel)
      1: begin
        s_ready = b_rdy; m_valid = b_mv; m_last = b_ml; ovs = b_ov;
        m_data = b_md; m_keep = b_mk; fill = b_fl; pkt = b_pc;
      end
      2: begin
        s_ready = c_rdy; m_valid = c_mv; m_last = c_ml; ovs = c_ov;
        m_data = c_md; m_keep = c_mk;
        fill = {1'b0, c_fl}; pkt = {1'b0, c_pc};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (q.size() != 0 || m_valid); n++) cyc();
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_fill", 64'(fill), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  // scoreboard: model accepted beats, compare popped beats
  always @(negedge clk) begin
    if (!reset) begin
      if (s_valid && s_ready && !(s_keep == 4'h0 && !s_last))
        q.push_back({s_last, s_keep, s_data});
      if (m_valid && m_ready) begin
        chk("pop_avail", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) chk("beat", 64'({m_last, m_keep, m_data}), 64'(q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_data", 64'({m_last, m_keep, m_data}), 64'd0);
    end
    sel = 0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("ready_after_rst", 64'(s_ready), 64'd1);

    // cut-through, 3-beat packet
    m_ready = 1'b1;
    send(32'hA000_0001, 4'hF, 1'b0);
    chk("ct_valid1", 64'(m_valid), 64'd1);
    chk("ct_data1", 64'(m_data), 64'hA000_0001);
    chk("ct_fill1", 64'(fill), 64'd1);
    send(32'hA000_0002, 4'hF, 1'b0);
    chk("ct_data2", 64'(m_data), 64'hA000_0002);
    chk("ct_fill2", 64'(fill), 64'd1);
    send(32'hA000_0003, 4'hF, 1'b1);
    chk("ct_data3", 64'({m_last, m_keep, m_data}), {27'd0, 1'b1, 4'hF, 32'hA000_0003});
    chk("ct_fill3", 64'(fill), 64'd1);
    cyc();
    chk("ct_empty", 64'({m_valid, fill}), 64'd0);

    // fill and backpressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'hB000_0000 + 32'(i), 4'hF, 1'b0);
    chk("bp_full_fill", 64'(fill), 64'd4);
    chk("bp_full_ready", 64'(s_ready), 64'd0);
    fork
      begin
        send(32'hB000_0005, 4'hF, 1'b0);
        send(32'hB000_0006, 4'hF, 1'b1);
      end
      begin
        cyc();
        cyc();
        m_ready = 1'b1;
        cyc();
        chk("bp_ready_back", 64'(s_ready), 64'd1);
        chk("bp_fill3", 64'(fill), 64'd3);
      end
    join
    drain();

    // null-beat drop
    do_reset();
    m_ready = 1'b0;
    send(32'hC000_0001, 4'hF, 1'b0);
    send(32'hC000_0002, 4'h0, 1'b0);
    chk("null_fill_a", 64'(fill), 64'd1);
    send(32'hC000_0003, 4'h0, 1'b1);
    chk("null_fill_b", 64'(fill), 64'd2);
    chk("null_pkt", 64'(pkt), 64'd1);
    m_ready = 1'b1;
    drain();

    // store-and-forward, 5 beats with gaps
    sel = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'hD000_0000 + 32'(i), 4'hF, 1'b0);
      chk("sf_hold", 64'(m_valid), 64'd0);
      repeat (2) cyc();
    end
    send(32'hD000_0004, 4'hF, 1'b1);
    chk("sf_release", 64'(m_valid), 64'd1);
    chk("sf_pkt1", 64'(pkt), 64'd1);
    chk("sf_fill5", 64'(fill), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("sf_burst", 64'(m_valid), 64'd1);
      cyc();
    end
    chk("sf_pkt0", 64'(pkt), 64'd0);
    chk("sf_done", 64'({m_valid, fill}), 64'd0);

    // oversize store-and-forward packet
    sel = 2;
    do_reset();
    for (int i = 0; i < 4; i++) send(32'hE000_0000 + 32'(i), 4'hF, 1'b0);
    chk("ov_fill4", 64'(fill), 64'd4);
    chk("ov_hold", 64'(m_valid), 64'd0);
    chk("ov_not_yet", 64'(ovs), 64'd0);
    cyc();
    chk("ov_flag", 64'(ovs), 64'd1);
    chk("ov_stream", 64'(m_valid), 64'd1);
    for (int i = 4; i < 7; i++) send(32'hE000_0000 + 32'(i), 4'hF, 1'(i == 6));
    drain();
    chk("ov_sticky", 64'(ovs), 64'd1);
    do_reset();
    chk("ov_cleared", 64'(ovs), 64'd0);

    // async reset mid-packet
    sel = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hF000_0000 + 32'(i), 4'hF, 1'b0);
    chk("ar_fill3", 64'(fill), 64'd3);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("ar_valid", 64'(m_valid), 64'd0);
    chk("ar_fill", 64'(fill), 64'd0);
    chk("ar_pkt", 64'(pkt), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("ar_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    send(32'h1234_5678, 4'hF, 1'b1);
    chk("ar_latency", 64'({m_valid, m_last, m_data}), {30'd0, 1'b1, 1'b1, 32'h1234_5678});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
